// File: rtl/jtsdram_arb_if.sv
// ---------------------------------------------------------------------------
// jtsdram_arb_if
//   Bundles every signal that crosses the arbiter boundary: the four bank
//   requesters on one side and the single-port SDRAM controller on the other.
//
//   modport master : the arbiter's view (drives SDRAM commands and the
//                    per-requester ack/rdy/data, plus the status flags)
//   modport slave  : the surrounding system's view (requesters + controller)
//
//   Requester side : req_rd[3:0], req_wr, ba0..ba3_addr, ba0_din, ba0_din_m,
//                    req_ack[3:0], req_rdy[3:0], req_dout
//   Controller side: sdram_rd, sdram_wr, sdram_ba, sdram_addr, sdram_din,
//                    sdram_din_m, sdram_ack, sdram_rdy, sdram_dout
//   Control/status : hold, busy, tout, last_ba
// ---------------------------------------------------------------------------
interface jtsdram_arb_if #(
  parameter int AW = 22,
  parameter int DW = 32
);
  // requester side
  logic [3:0]    req_rd;
  logic          req_wr;
  logic [AW-1:0] ba0_addr;
  logic [AW-1:0] ba1_addr;
  logic [AW-1:0] ba2_addr;
  logic [AW-1:0] ba3_addr;
  logic [15:0]   ba0_din;
  logic [1:0]    ba0_din_m;
  logic [3:0]    req_ack;
  logic [3:0]    req_rdy;
  logic [DW-1:0] req_dout;

  // controller side
  logic          sdram_rd;
  logic          sdram_wr;
  logic [1:0]    sdram_ba;
  logic [AW-1:0] sdram_addr;
  logic [15:0]   sdram_din;
  logic [1:0]    sdram_din_m;
  logic          sdram_ack;
  logic          sdram_rdy;
  logic [DW-1:0] sdram_dout;

  // control / status
  logic          hold;
  logic          busy;
  logic          tout;
  logic [1:0]    last_ba;

  modport master (
    input  req_rd, req_wr, ba0_addr, ba1_addr, ba2_addr, ba3_addr,
           ba0_din, ba0_din_m, sdram_ack, sdram_rdy, sdram_dout, hold,
    output req_ack, req_rdy, req_dout, sdram_rd, sdram_wr, sdram_ba,
           sdram_addr, sdram_din, sdram_din_m, busy, tout, last_ba
  );

  modport slave (
    output req_rd, req_wr, ba0_addr, ba1_addr, ba2_addr, ba3_addr,
           ba0_din, ba0_din_m, sdram_ack, sdram_rdy, sdram_dout, hold,
    input  req_ack, req_rdy, req_dout, sdram_rd, sdram_wr, sdram_ba,
           sdram_addr, sdram_din, sdram_din_m, busy, tout, last_ba
  );
endinterface

// File: rtl/jtsdram_arb.sv
// ---------------------------------------------------------------------------
// jtsdram_arb
//   Round-robin arbiter sharing one single-port SDRAM command interface among
//   four bank requesters. Requester 0 may read or write, requesters 1-3 only
//   read. One transaction is outstanding at a time; ack/rdy/data are routed
//   back to the owner, and a controller that never returns rdy after ack is
//   flagged by a sticky timeout.
//
//   Ports:
//     clk    : system clock
//     rst_n  : synchronous active-low reset
//     bus    : jtsdram_arb_if.master (requesters, controller, hold/status)
//
//   Parameters:
//     AW   : address width (requester and SDRAM word address)
//     DW   : read data width
//     TOUT : WAIT cycles without sdram_rdy before timing out (1..1023)
// ---------------------------------------------------------------------------
module jtsdram_arb #(
  parameter int AW   = 22,
  parameter int DW   = 32,
  parameter int TOUT = 1023
) (
  input  logic                clk,
  input  logic                rst_n,
  jtsdram_arb_if.master       bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // Last WAIT count value before the timeout fires: the counter starts at 0
  // on the first WAIT cycle, so TOUT WAIT cycles end when it equals TOUT-1.
  localparam logic [9:0] TOUT_LAST = 10'(TOUT - 1);

  // -------------------------------------------------------------------------
  // State and registered outputs
  // -------------------------------------------------------------------------
  state_t        r_state;
  logic [1:0]    r_ptr;
  logic [9:0]    r_cnt;
  logic          r_sdram_rd;
  logic          r_sdram_wr;
  logic [1:0]    r_sdram_ba;
  logic [AW-1:0] r_sdram_addr;
  logic [15:0]   r_sdram_din;
  logic [1:0]    r_sdram_din_m;
  logic [3:0]    r_req_ack;
  logic [3:0]    r_req_rdy;
  logic [DW-1:0] r_req_dout;
  logic          r_busy;
  logic          r_tout;
  logic [1:0]    r_last_ba;

  state_t        w_state_next;
  logic [1:0]    w_ptr_next;
  logic [9:0]    w_cnt_next;
  logic          w_sdram_rd_next;
  logic          w_sdram_wr_next;
  logic [1:0]    w_sdram_ba_next;
  logic [AW-1:0] w_sdram_addr_next;
  logic [15:0]   w_sdram_din_next;
  logic [1:0]    w_sdram_din_m_next;
  logic [3:0]    w_req_ack_next;
  logic [3:0]    w_req_rdy_next;
  logic [DW-1:0] w_req_dout_next;
  logic          w_busy_next;
  logic          w_tout_next;
  logic [1:0]    w_last_ba_next;

  // -------------------------------------------------------------------------
  // Requester address table and round-robin search
  // -------------------------------------------------------------------------
  logic [AW-1:0] w_addr_arr [4];
  logic [1:0]    w_cand     [4];
  logic [3:0]    w_hit;
  logic [3:0]    w_owner_oh;
  logic [1:0]    w_win;

  assign w_addr_arr[0] = bus.ba0_addr;
  assign w_addr_arr[1] = bus.ba1_addr;
  assign w_addr_arr[2] = bus.ba2_addr;
  assign w_addr_arr[3] = bus.ba3_addr;

  // w_cand[k] is the requester examined k-th, starting just after the last
  // winner; the 2-bit add wraps modulo 4 naturally.
  for (genvar gi = 0; gi < 4; gi++) begin : g_search
    assign w_cand[gi] = r_ptr + 2'(gi + 1);
    assign w_hit[gi]  = bus.req_rd[w_cand[gi]];
  end

  // The owner of the transaction in flight is the registered bank select.
  for (genvar gi = 0; gi < 4; gi++) begin : g_owner
    assign w_owner_oh[gi] = (r_sdram_ba == 2'(gi));
  end

  always_comb begin
    w_win = w_cand[3];
    if (w_hit[0])      w_win = w_cand[0];
    else if (w_hit[1]) w_win = w_cand[1];
    else if (w_hit[2]) w_win = w_cand[2];
  end

  // -------------------------------------------------------------------------
  // Next-state and output logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next       = r_state;
    w_ptr_next         = r_ptr;
    w_cnt_next         = r_cnt;
    w_sdram_rd_next    = r_sdram_rd;
    w_sdram_wr_next    = r_sdram_wr;
    w_sdram_ba_next    = r_sdram_ba;
    w_sdram_addr_next  = r_sdram_addr;
    w_sdram_din_next   = r_sdram_din;
    w_sdram_din_m_next = r_sdram_din_m;
    w_req_ack_next     = 4'd0;   // ack/rdy are single-cycle pulses
    w_req_rdy_next     = 4'd0;
    w_req_dout_next    = r_req_dout;
    w_busy_next        = r_busy;
    w_tout_next        = r_tout;
    w_last_ba_next     = r_last_ba;

    case (r_state)
      ST_IDLE: begin
        // sdram_rdy is deliberately ignored here: nothing is outstanding.
        if (!bus.hold && (|bus.req_rd)) begin
          w_sdram_ba_next    = w_win;
          w_sdram_addr_next  = w_addr_arr[w_win];
          // Only requester 0 carries write data; others register zeros.
          w_sdram_din_next   = (w_win == 2'd0) ? bus.ba0_din   : 16'd0;
          w_sdram_din_m_next = (w_win == 2'd0) ? bus.ba0_din_m : 2'd0;
          w_sdram_wr_next    = (w_win == 2'd0) && bus.req_wr;
          w_sdram_rd_next    = !((w_win == 2'd0) && bus.req_wr);
          w_ptr_next         = w_win;
          w_last_ba_next     = w_win;
          w_busy_next        = 1'b1;
          w_state_next       = ST_CMD;
        end
      end

      ST_CMD: begin
        // No timeout here: the controller may hold off acceptance forever.
        if (bus.sdram_ack) begin
          w_sdram_rd_next = 1'b0;
          w_sdram_wr_next = 1'b0;
          w_req_ack_next  = w_owner_oh;
          w_cnt_next      = 10'd0;
          if (bus.sdram_rdy) begin
            // Controller accepted and completed in the same cycle.
            w_req_rdy_next  = w_owner_oh;
            w_req_dout_next = bus.sdram_dout;
            w_busy_next     = 1'b0;
            w_state_next    = ST_IDLE;
          end else begin
            w_state_next    = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (bus.sdram_rdy) begin
          w_req_rdy_next  = w_owner_oh;
          w_req_dout_next = bus.sdram_dout;
          w_busy_next     = 1'b0;
          w_state_next    = ST_IDLE;
        end else if (r_cnt == TOUT_LAST) begin
          // Release the owner with its old data so it does not hang.
          w_tout_next    = 1'b1;
          w_req_rdy_next = w_owner_oh;
          w_busy_next    = 1'b0;
          w_state_next   = ST_IDLE;
        end else begin
          w_cnt_next = r_cnt + 10'd1;
        end
      end

      default: begin
        w_state_next    = ST_IDLE;
        w_sdram_rd_next = 1'b0;
        w_sdram_wr_next = 1'b0;
        w_busy_next     = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_ptr         <= 2'd3;     // requester 0 searched first after reset
      r_cnt         <= 10'd0;
      r_sdram_rd    <= 1'b0;
      r_sdram_wr    <= 1'b0;
      r_sdram_ba    <= 2'd0;
      r_sdram_addr  <= '0;
      r_sdram_din   <= 16'd0;
      r_sdram_din_m <= 2'd0;
      r_req_ack     <= 4'd0;
      r_req_rdy     <= 4'd0;
      r_req_dout    <= '0;
      r_busy        <= 1'b0;
      r_tout        <= 1'b0;
      r_last_ba     <= 2'd0;
    end else begin
      r_state       <= w_state_next;
      r_ptr         <= w_ptr_next;
      r_cnt         <= w_cnt_next;
      r_sdram_rd    <= w_sdram_rd_next;
      r_sdram_wr    <= w_sdram_wr_next;
      r_sdram_ba    <= w_sdram_ba_next;
      r_sdram_addr  <= w_sdram_addr_next;
      r_sdram_din   <= w_sdram_din_next;
      r_sdram_din_m <= w_sdram_din_m_next;
      r_req_ack     <= w_req_ack_next;
      r_req_rdy     <= w_req_rdy_next;
      r_req_dout    <= w_req_dout_next;
      r_busy        <= w_busy_next;
      r_tout        <= w_tout_next;
      r_last_ba     <= w_last_ba_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.sdram_rd    = r_sdram_rd;
  assign bus.sdram_wr    = r_sdram_wr;
  assign bus.sdram_ba    = r_sdram_ba;
  assign bus.sdram_addr  = r_sdram_addr;
  assign bus.sdram_din   = r_sdram_din;
  assign bus.sdram_din_m = r_sdram_din_m;
  assign bus.req_ack     = r_req_ack;
  assign bus.req_rdy     = r_req_rdy;
  assign bus.req_dout    = r_req_dout;
  assign bus.busy        = r_busy;
  assign bus.tout        = r_tout;
  assign bus.last_ba     = r_last_ba;

endmodule

// File: doc/jtsdram_arb.md
Name: jtsdram_arb

Overview:
- Round-robin arbiter that shares one single-port SDRAM command interface between four bank requesters.
- Requester 0 may read or write; requesters 1-3 are read-only.
- Sits between the per-bank test channels and the SDRAM controller.
- Serialises requests with one outstanding transaction, routes ack/rdy/data back to the owner, and flags a stalled controller with a timeout.

Parameters:
- AW, 22, requester and SDRAM word address width.
- DW, 32, read data width.
- TOUT, 1023, cycles to wait for sdram_rdy after sdram_ack before flagging timeout; must be ≥1 and fit in 10 bits.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- req_rd  in  4  per-requester request; level, held until that requester's rdy
- req_wr  in  1  requester 0 write qualifier, sampled with req_rd[0]
- ba0_addr, ba1_addr, ba2_addr, ba3_addr  in  AW each  requester addresses
- ba0_din  in  16  requester 0 write data
- ba0_din_m  in  2  requester 0 write mask
- req_ack  out  4  one-cycle pulse to owner when controller accepts
- req_rdy  out  4  one-cycle pulse to owner when data is valid / write done
- req_dout  out  DW  read data, valid with any req_rdy bit
- sdram_rd  out  1  read command to controller
- sdram_wr  out  1  write command to controller
- sdram_ba  out  2  bank select = granted requester index
- sdram_addr  out  AW  granted address
- sdram_din  out  16  write data
- sdram_din_m  out  2  write mask
- sdram_ack  in  1  controller accepted command
- sdram_rdy  in  1  controller completed command
- sdram_dout  in  DW  controller read data
- hold  in  1  when high, no new grant is issued (refresh window)
- busy  out  1  transaction in progress
- tout  out  1  sticky timeout flag
- last_ba  out  2  index of most recent grant

Behaviour:
- Reset (rst_n low at clk edge):
  - state IDLE; all outputs 0.
  - Round-robin pointer = 3, so requester 0 has first priority.
  - tout cleared.
- States: IDLE, CMD, WAIT.
- IDLE:
  - If hold = 0 and any req_rd is set, grant the first set bit searching from pointer+1 (mod 4).
  - Register sdram_ba, sdram_addr, din and mask from the winner.
  - sdram_rd = 1, or sdram_wr = 1 when winner is 0 and req_wr = 1; sdram_wr is never set for winners 1-3.
  - pointer = winner; last_ba = winner; busy = 1; go to CMD.
  - Decision takes one cycle: command is visible the cycle after the request is first seen.
- CMD:
  - Outputs held stable until sdram_ack.
  - On sdram_ack: drop sdram_rd/sdram_wr the next cycle, pulse req_ack[winner] for one cycle, clear the timeout counter, go to WAIT.
  - No timeout in CMD; the controller may stall acceptance indefinitely.
- WAIT:
  - Counter increments each cycle.
  - On sdram_rdy: latch sdram_dout into req_dout, pulse req_rdy[winner] for one cycle, busy = 0, go to IDLE.
  - The next grant may start the cycle after the rdy pulse; no back-to-back grant in the same cycle.
  - If the counter reaches TOUT: set tout (sticky until reset), pulse req_rdy[winner] with req_dout unchanged so the owner unblocks, go to IDLE.
- Simultaneous sdram_ack and sdram_rdy in CMD: both accepted; req_ack and req_rdy pulse on the same cycle, data latched, return to IDLE.
- sdram_rdy in IDLE is ignored.
- A requester that drops req_rd after being granted is still served to completion; the arbiter never aborts.
- hold affects only IDLE; a transaction in flight completes during hold.
- Fairness: with all four requesting continuously, grant order is 0,1,2,3,0,... Each requester waits at most 3 transactions.
- req_dout keeps its last value between rdy pulses.
- Reset mid-transaction: immediate return to IDLE, commands dropped, no ack/rdy pulses issued.

Test Plan:
- Reset, then req_rd=4'b0100 with ba2_addr=22'h1234 → next cycle sdram_rd=1, sdram_ba=2, sdram_addr=22'h1234; sdram_ack → req_ack=4'b0100 one cycle; sdram_rdy with dout=32'hCAFEBABE → req_rdy=4'b0100, req_dout=32'hCAFEBABE.
- req_rd=4'b1111 held continuously, controller acks/rdys after 2 cycles → grants 0,1,2,3,0 in order; last_ba follows.
- req_rd[0]=1, req_wr=1, din=16'hA55A, mask=2'b01 → sdram_wr=1, sdram_rd=0, sdram_din=16'hA55A, sdram_din_m=2'b01.
- req_wr=1 while only req_rd[3] set → sdram_rd=1, sdram_wr=0.
- hold=1 with req_rd=4'b0010 → no command for 50 cycles; hold drops → command the next cycle. hold raised while in WAIT → transaction still completes.
- TOUT=8, sdram_ack then no sdram_rdy → tout=1 after 8 WAIT cycles, req_rdy pulses, state IDLE; tout remains 1 until rst_n=0.
